// File: rtl/dcache_mshr_scheduler_pkg.sv
// Shared types and constants for the D-cache MSHR scheduler.
// The build-time macro RSD_MARCH_DCACHE_MSHR_MERGE_EN enables miss merging.
package dcache_mshr_scheduler_pkg;

  localparam int CONF_DCACHE_MSHR_NUM      = 2;
  localparam int CONF_MEM_ISSUE_WIDTH      = 2;
  localparam int CONF_DCACHE_LINE_BYTE_NUM = 8;

  localparam int MSHR_NUM        = CONF_DCACHE_MSHR_NUM;
  localparam int LINE_ADDR_WIDTH = 32 - $clog2(CONF_DCACHE_LINE_BYTE_NUM);

  typedef logic [$clog2(MSHR_NUM)-1:0] MSHR_IndexPath;
  typedef logic [LINE_ADDR_WIDTH-1:0]  MissLineAddrPath;

  typedef enum logic [1:0] {
    MSHR_FREE = 2'd0,
    MSHR_REQ  = 2'd1,
    MSHR_WAIT = 2'd2,
    MSHR_FILL = 2'd3
  } MSHR_StatePath;

endpackage

// File: rtl/dcache_mshr_scheduler_entry.sv
// One MSHR entry: state register, latched line address and merge comparator.
// Comparator exists only when RSD_MARCH_DCACHE_MSHR_MERGE_EN is defined.
//   state     | meaning
//   MSHR_FREE | unused, allocatable
//   MSHR_REQ  | line read waiting for the memory port
//   MSHR_WAIT | request accepted, awaiting line data
//   MSHR_FILL | data returned, cache array write in progress
module dcache_mshr_entry
  import dcache_mshr_scheduler_pkg::*;
#(
  parameter int LANE_NUM = 2,
  parameter int ADDR_W   = 29
) (
  input  logic                clk_i,
  input  logic                rstN_i,
  input  logic                alloc_i,
  input  logic [ADDR_W-1:0]   allocAddr_i,
  input  logic                issueAcc_i,
  input  logic                respHit_i,
  input  logic                fillHit_i,
  input  logic [ADDR_W-1:0]   cmpAddr_i [LANE_NUM],
  output MSHR_StatePath       state_o,
  output logic [ADDR_W-1:0]   addr_o,
  output logic [LANE_NUM-1:0] hitActive_o,
  output logic [LANE_NUM-1:0] hitFill_o
);

  MSHR_StatePath     state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;

  always_ff @(posedge clk_i or negedge rstN_i) begin
    if (!rstN_i) begin
      state_q <= MSHR_FREE;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    unique case (state_q)
      MSHR_FREE: if (alloc_i) begin
        state_d = MSHR_REQ;
        addr_d  = allocAddr_i;
      end
      MSHR_REQ:  if (issueAcc_i) state_d = MSHR_WAIT;
      MSHR_WAIT: if (respHit_i)  state_d = MSHR_FILL;
      MSHR_FILL: if (fillHit_i)  state_d = MSHR_FREE;
      default:   state_d = MSHR_FREE;
    endcase
  end

  assign state_o = state_q;
  assign addr_o  = addr_q;

`ifdef RSD_MARCH_DCACHE_MSHR_MERGE_EN
  always_comb begin
    hitActive_o = '0;
    hitFill_o   = '0;
    for (int l = 0; l < LANE_NUM; l++) begin
      hitActive_o[l] = (cmpAddr_i[l] == addr_q) &&
                       ((state_q == MSHR_REQ) || (state_q == MSHR_WAIT));
      hitFill_o[l]   = (cmpAddr_i[l] == addr_q) && (state_q == MSHR_FILL);
    end
  end
`else
  logic [LANE_NUM-1:0] unused_cmp;
  always_comb begin
    unused_cmp = '0;
    for (int l = 0; l < LANE_NUM; l++) unused_cmp[l] = ^cmpAddr_i[l];
  end
  assign hitActive_o = '0;
  assign hitFill_o   = '0;
`endif

endmodule

// File: rtl/dcache_mshr_scheduler.sv
// MSHR allocator, round-robin lane arbiter and memory request port picker.
// Miss merging into in-flight entries is built only with RSD_MARCH_DCACHE_MSHR_MERGE_EN.
module dcache_mshr_scheduler
  import dcache_mshr_scheduler_pkg::*;
#(
  parameter int MSHR_NUM        = dcache_mshr_scheduler_pkg::MSHR_NUM,
  parameter int REQ_NUM         = dcache_mshr_scheduler_pkg::CONF_MEM_ISSUE_WIDTH,
  parameter int LINE_ADDR_WIDTH = dcache_mshr_scheduler_pkg::LINE_ADDR_WIDTH
) (
  input  logic                        clk_i,
  input  logic                        rstN_i,
  input  logic [REQ_NUM-1:0]          missReq_i,
  input  logic [LINE_ADDR_WIDTH-1:0]  missAddr_i [REQ_NUM],
  output logic [REQ_NUM-1:0]          missGrant_o,
  output logic [$clog2(MSHR_NUM)-1:0] missGrantId_o [REQ_NUM],
  output logic [REQ_NUM-1:0]          missMerged_o,
  output logic                        memReq_o,
  output logic [LINE_ADDR_WIDTH-1:0]  memReqAddr_o,
  output logic [$clog2(MSHR_NUM)-1:0] memReqId_o,
  input  logic                        memReqReady_i,
  input  logic                        memRespValid_i,
  input  logic [$clog2(MSHR_NUM)-1:0] memRespId_i,
  input  logic                        fillDone_i,
  input  logic [$clog2(MSHR_NUM)-1:0] fillDoneId_i,
  output logic [MSHR_NUM-1:0]         mshrBusy_o,
  output logic                        mshrFull_o
);

  localparam int IDX_W = $clog2(MSHR_NUM);
  localparam int PTR_W = $clog2(REQ_NUM);

  MSHR_StatePath              state      [MSHR_NUM];
  logic [LINE_ADDR_WIDTH-1:0] addr       [MSHR_NUM];
  logic [REQ_NUM-1:0]         hit_active [MSHR_NUM];
  logic [REQ_NUM-1:0]         hit_fill   [MSHR_NUM];
  logic [MSHR_NUM-1:0]        alloc_en, issue_acc, resp_en, fill_en;

  logic                       free_any;
  logic [IDX_W-1:0]           free_idx;
  logic [REQ_NUM-1:0]         merge_hit, blocked, need_alloc;
  logic [IDX_W-1:0]           merge_id [REQ_NUM];
  logic                       win_vld;
  logic [PTR_W-1:0]           win;
  logic                       req_any;
  logic [IDX_W-1:0]           req_idx;

  logic [PTR_W-1:0]           rr_ptr_q, rr_ptr_d;
  logic                       lock_q, lock_d;
  logic [IDX_W-1:0]           lock_id_q, lock_id_d;

  for (genvar g = 0; g < MSHR_NUM; g++) begin : g_entry
    dcache_mshr_entry #(
      .LANE_NUM (REQ_NUM),
      .ADDR_W   (LINE_ADDR_WIDTH)
    ) u_entry (
      .clk_i       (clk_i),
      .rstN_i      (rstN_i),
      .alloc_i     (alloc_en[g]),
      .allocAddr_i (missAddr_i[win]),
      .issueAcc_i  (issue_acc[g]),
      .respHit_i   (resp_en[g]),
      .fillHit_i   (fill_en[g]),
      .cmpAddr_i   (missAddr_i),
      .state_o     (state[g]),
      .addr_o      (addr[g]),
      .hitActive_o (hit_active[g]),
      .hitFill_o   (hit_fill[g])
    );
  end

  always_comb begin
    free_any = 1'b0;
    free_idx = '0;
    for (int i = MSHR_NUM - 1; i >= 0; i--) begin
      if (state[i] == MSHR_FREE) begin
        free_any = 1'b1;
        free_idx = IDX_W'(i);
      end
    end
  end

  // Merge candidates and lanes stalled behind a line that is still filling.
  always_comb begin
    merge_hit = '0;
    blocked   = '0;
    for (int l = 0; l < REQ_NUM; l++) begin
      merge_id[l] = '0;
      for (int i = MSHR_NUM - 1; i >= 0; i--) begin
        if (hit_active[i][l]) begin
          merge_hit[l] = missReq_i[l];
          merge_id[l]  = IDX_W'(i);
        end
        if (hit_fill[i][l]) blocked[l] = 1'b1;
      end
    end
    need_alloc = missReq_i & ~merge_hit & ~blocked;
  end

  always_comb begin
    int lane;
    win_vld = 1'b0;
    win     = '0;
    for (int k = 0; k < REQ_NUM; k++) begin
      lane = (int'(rr_ptr_q) + k) % REQ_NUM;
      if (!win_vld && free_any && rstN_i && need_alloc[lane]) begin
        win_vld = 1'b1;
        win     = PTR_W'(lane);
      end
    end
    rr_ptr_d = win_vld ? PTR_W'((int'(win) + 1) % REQ_NUM) : rr_ptr_q;
  end

  always_comb begin
    for (int l = 0; l < REQ_NUM; l++) begin
      missGrant_o[l]   = rstN_i && (merge_hit[l] || (win_vld && (win == PTR_W'(l))));
      missGrantId_o[l] = !missGrant_o[l] ? '0 : (merge_hit[l] ? merge_id[l] : free_idx);
    end
  end

`ifdef RSD_MARCH_DCACHE_MSHR_MERGE_EN
  assign missMerged_o = merge_hit & {REQ_NUM{rstN_i}};
`else
  assign missMerged_o = '0;
`endif

  // A stalled request stays pinned so a newly allocated lower entry cannot swap it.
  always_comb begin
    req_any = 1'b0;
    req_idx = '0;
    for (int i = MSHR_NUM - 1; i >= 0; i--) begin
      if (state[i] == MSHR_REQ) begin
        req_any = 1'b1;
        req_idx = IDX_W'(i);
      end
    end
    if (lock_q) begin
      req_any = 1'b1;
      req_idx = lock_id_q;
    end
    lock_d    = req_any && !memReqReady_i;
    lock_id_d = req_idx;
  end

  assign memReq_o     = req_any;
  assign memReqId_o   = req_idx;
  assign memReqAddr_o = req_any ? addr[req_idx] : '0;

  always_comb begin
    for (int i = 0; i < MSHR_NUM; i++) begin
      alloc_en[i]   = win_vld && (free_idx == IDX_W'(i));
      issue_acc[i]  = req_any && memReqReady_i && (req_idx == IDX_W'(i));
      resp_en[i]    = memRespValid_i && (memRespId_i == IDX_W'(i));
      fill_en[i]    = fillDone_i && (fillDoneId_i == IDX_W'(i));
      mshrBusy_o[i] = (state[i] != MSHR_FREE);
    end
  end

  assign mshrFull_o = !free_any;

  always_ff @(posedge clk_i or negedge rstN_i) begin
    if (!rstN_i) begin
      rr_ptr_q  <= '0;
      lock_q    <= 1'b0;
      lock_id_q <= '0;
    end else begin
      rr_ptr_q  <= rr_ptr_d;
      lock_q    <= lock_d;
      lock_id_q <= lock_id_d;
    end
  end

endmodule

// File: tb/tb_dcache_mshr_scheduler.sv
// Self-checking bench for dcache_mshr_scheduler: directed scenarios plus a
// randomized run against a queue/array reference model.
module tb_dcache_mshr_scheduler;

  localparam int MN = 2;
  localparam int RN = 2;
  localparam int AW = 29;
  localparam int IW = 1;

  logic          clk = 1'b0;
  logic          rstN;
  logic [RN-1:0] missReq;
  logic [AW-1:0] missAddr [RN];
  logic [RN-1:0] missGrant;
  logic [IW-1:0] missGrantId [RN];
  logic [RN-1:0] missMerged;
  logic          memReq;
  logic [AW-1:0] memReqAddr;
  logic [IW-1:0] memReqId;
  logic          memReqReady;
  logic          memRespValid;
  logic [IW-1:0] memRespId;
  logic          fillDone;
  logic [IW-1:0] fillDoneId;
  logic [MN-1:0] mshrBusy;
  logic          mshrFull;

  int tests = 0;
  int fails = 0;

  dcache_mshr_scheduler dut (
    .clk_i          (clk),
    .rstN_i         (rstN),
    .missReq_i      (missReq),
    .missAddr_i     (missAddr),
    .missGrant_o    (missGrant),
    .missGrantId_o  (missGrantId),
    .missMerged_o   (missMerged),
    .memReq_o       (memReq),
    .memReqAddr_o   (memReqAddr),
    .memReqId_o     (memReqId),
    .memReqReady_i  (memReqReady),
    .memRespValid_i (memRespValid),
    .memRespId_i    (memRespId),
    .fillDone_i     (fillDone),
    .fillDoneId_i   (fillDoneId),
    .mshrBusy_o     (mshrBusy),
    .mshrFull_o     (mshrFull)
  );

  always #5 clk = ~clk;

  task automatic idle();
    missReq = '0;
    for (int l = 0; l < RN; l++) missAddr[l] = '0;
    memReqReady = 1'b0; memRespValid = 1'b0; memRespId = '0;
    fillDone = 1'b0; fillDoneId = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rstN = 1'b0;
    idle();
    tick();
    tick();
    rstN = 1'b1;
  endtask

  task automatic test_reset();
    rstN = 1'b0;
    idle();
    missReq = 2'b11; missAddr[0] = 29'h1000; missAddr[1] = 29'h2000;
    #1;
    tests++; if (missGrant !== 2'b00) begin fails++; $display("FAIL reset_grant got=%b exp=00", missGrant); end
    tests++; if (memReq !== 1'b0) begin fails++; $display("FAIL reset_memreq got=%b exp=0", memReq); end
    tests++; if (mshrBusy !== 2'b00 || mshrFull !== 1'b0) begin fails++; $display("FAIL reset_busy got=%b/%b exp=00/0", mshrBusy, mshrFull); end
    tick();
    rstN = 1'b1; idle();
    #1;
    tests++; if (mshrBusy !== 2'b00 || memReq !== 1'b0) begin fails++; $display("FAIL reset_release got=%b/%b exp=00/0", mshrBusy, memReq); end
  endtask

  task automatic test_basic_alloc();
    do_reset();
    missReq = 2'b01; missAddr[0] = 29'h1000;
    #1;
    tests++; if (missGrant !== 2'b01 || missGrantId[0] !== 1'b0 || missMerged !== 2'b00) begin fails++; $display("FAIL alloc_grant got=%b id=%0d m=%b exp=01 id=0 m=00", missGrant, missGrantId[0], missMerged); end
    tests++; if (memReq !== 1'b0) begin fails++; $display("FAIL alloc_samecycle_memreq got=%b exp=0", memReq); end
    tick();
    missReq = '0;
    for (int c = 0; c < 4; c++) begin
      #1;
      tests++; if (memReq !== 1'b1 || memReqAddr !== 29'h1000 || memReqId !== 1'b0) begin fails++; $display("FAIL memreq_hold c=%0d got=%b %h %0d exp=1 1000 0", c, memReq, memReqAddr, memReqId); end
      if (c < 3) tick();
    end
    memReqReady = 1'b1;
    tick();
    memReqReady = 1'b0;
    #1;
    tests++; if (memReq !== 1'b0 || mshrBusy !== 2'b01) begin fails++; $display("FAIL to_wait got=%b busy=%b exp=0 busy=01", memReq, mshrBusy); end
    memRespValid = 1'b1; memRespId = 1'b0;
    tick();
    memRespValid = 1'b0; fillDone = 1'b1; fillDoneId = 1'b0;
    #1;
    tests++; if (mshrBusy !== 2'b01) begin fails++; $display("FAIL in_fill busy got=%b exp=01", mshrBusy); end
    tick();
    fillDone = 1'b0;
    #1;
    tests++; if (mshrBusy !== 2'b00) begin fails++; $display("FAIL freed busy got=%b exp=00", mshrBusy); end
  endtask

  task automatic test_round_robin();
    do_reset();
    missReq = 2'b11; missAddr[0] = 29'h2000; missAddr[1] = 29'h3000;
    #1;
    tests++; if (missGrant !== 2'b01 || missGrantId[0] !== 1'b0) begin fails++; $display("FAIL rr_first got=%b id=%0d exp=01 id=0", missGrant, missGrantId[0]); end
    tick();
    missAddr[0] = 29'h2800;
    #1;
    tests++; if (missGrant !== 2'b10 || missGrantId[1] !== 1'b1) begin fails++; $display("FAIL rr_second got=%b id=%0d exp=10 id=1", missGrant, missGrantId[1]); end
    tick();
    missReq = '0;
    #1;
    tests++; if (mshrBusy !== 2'b11 || mshrFull !== 1'b1) begin fails++; $display("FAIL rr_full got=%b/%b exp=11/1", mshrBusy, mshrFull); end
  endtask

  task automatic test_full_and_free();
    do_reset();
    missReq = 2'b01; missAddr[0] = 29'h100; tick();
    missAddr[0] = 29'h200; tick();
    missReq = '0;
    #1;
    tests++; if (mshrFull !== 1'b1) begin fails++; $display("FAIL full_flag got=%b exp=1", mshrFull); end
    missReq = 2'b01; missAddr[0] = 29'h300;
    #1;
    tests++; if (missGrant !== 2'b00) begin fails++; $display("FAIL full_nogrant got=%b exp=00", missGrant); end
    missReq = '0; memReqReady = 1'b1;
    tick(); tick();
    memReqReady = 1'b0;
    memRespValid = 1'b1; memRespId = 1'b1;
    tick();
    memRespValid = 1'b0;
    fillDone = 1'b1; fillDoneId = 1'b1; missReq = 2'b01; missAddr[0] = 29'h300;
    #1;
    tests++; if (missGrant !== 2'b00) begin fails++; $display("FAIL free_same_cycle got=%b exp=00", missGrant); end
    tick();
    fillDone = 1'b0;
    #1;
    tests++; if (missGrant !== 2'b01 || missGrantId[0] !== 1'b1) begin fails++; $display("FAIL free_next_cycle got=%b id=%0d exp=01 id=1", missGrant, missGrantId[0]); end
    tests++; if (mshrBusy !== 2'b01 || mshrFull !== 1'b0) begin fails++; $display("FAIL free_busy got=%b/%b exp=01/0", mshrBusy, mshrFull); end
    tick();
    idle();
  endtask

  task automatic test_resp_fill_same_cycle();
    do_reset();
    missReq = 2'b01; missAddr[0] = 29'h5000; tick();
    missAddr[0] = 29'h6000; tick();
    missReq = '0; memReqReady = 1'b1;
    tick(); tick();
    memReqReady = 1'b0;
    memRespValid = 1'b1; memRespId = 1'b1;
    tick();
    memRespId = 1'b0; fillDone = 1'b1; fillDoneId = 1'b1;
    tick();
    memRespValid = 1'b0; fillDone = 1'b0;
    #1;
    tests++; if (mshrBusy !== 2'b01) begin fails++; $display("FAIL resp_fill_busy got=%b exp=01", mshrBusy); end
    fillDone = 1'b1; fillDoneId = 1'b0;
    tick();
    fillDone = 1'b0;
    #1;
    tests++; if (mshrBusy !== 2'b00) begin fails++; $display("FAIL entry0_was_fill got=%b exp=00", mshrBusy); end
  endtask

  task automatic test_merge();
    do_reset();
    missReq = 2'b10; missAddr[1] = 29'h4000; tick();
    missReq = '0; memReqReady = 1'b1; tick();
    memReqReady = 1'b0;
    missReq = 2'b11; missAddr[0] = 29'h4000; missAddr[1] = 29'h4000;
    #1;
`ifdef RSD_MARCH_DCACHE_MSHR_MERGE_EN
    tests++; if (missGrant !== 2'b11 || missMerged !== 2'b11 || missGrantId[0] !== 1'b0 || missGrantId[1] !== 1'b0) begin fails++; $display("FAIL merge_grant got=%b m=%b ids=%0d,%0d exp=11 m=11 ids=0,0", missGrant, missMerged, missGrantId[0], missGrantId[1]); end
    tick();
    missReq = '0;
    #1;
    tests++; if (mshrBusy !== 2'b01) begin fails++; $display("FAIL merge_noalloc got=%b exp=01", mshrBusy); end
    memRespValid = 1'b1; memRespId = 1'b0;
    tick();
    memRespValid = 1'b0; missReq = 2'b01;
    #1;
    tests++; if (missGrant !== 2'b00) begin fails++; $display("FAIL merge_fill_block got=%b exp=00", missGrant); end
`else
    tests++; if (missGrant !== 2'b01 || missGrantId[0] !== 1'b1 || missMerged !== 2'b00) begin fails++; $display("FAIL nomerge_grant got=%b id=%0d m=%b exp=01 id=1 m=00", missGrant, missGrantId[0], missMerged); end
    tick();
    missReq = '0;
    #1;
    tests++; if (mshrBusy !== 2'b11) begin fails++; $display("FAIL nomerge_alloc got=%b exp=11", mshrBusy); end
`endif
    idle();
  endtask

  task automatic test_reset_midop();
    do_reset();
    missReq = 2'b01; missAddr[0] = 29'h8000; tick();
    missAddr[0] = 29'h9000; memReqReady = 1'b1; tick();
    missReq = '0; memReqReady = 1'b0;
    #1;
    tests++; if (mshrBusy !== 2'b11 || memReq !== 1'b1 || memReqId !== 1'b1) begin fails++; $display("FAIL midop_setup got=%b %b %0d exp=11 1 1", mshrBusy, memReq, memReqId); end
    #2;
    rstN = 1'b0;
    #1;
    tests++; if (mshrBusy !== 2'b00 || memReq !== 1'b0 || mshrFull !== 1'b0) begin fails++; $display("FAIL midop_reset got=%b %b %b exp=00 0 0", mshrBusy, memReq, mshrFull); end
    @(negedge clk);
    tick();
    rstN = 1'b1;
    missReq = 2'b11; missAddr[0] = 29'hA000; missAddr[1] = 29'hB000;
    #1;
    tests++; if (missGrant !== 2'b01 || missGrantId[0] !== 1'b0) begin fails++; $display("FAIL midop_first_grant got=%b id=%0d exp=01 id=0", missGrant, missGrantId[0]); end
    tick();
    idle();
  endtask

  task automatic test_random();
    logic [AW-1:0] pool [4];
    int            st [MN];
    int            old [MN];
    logic [AW-1:0] ad [MN];
    int            rr, cur, free_idx, win, e_rid;
    bit            e_req, e_g;
    bit            mrg [RN];
    bit            blk [RN];
    int            mid [RN];
    int            wq[$];
    int            fq[$];
    logic [MN-1:0] e_busy;
    pool[0] = 29'h10; pool[1] = 29'h20; pool[2] = 29'h30; pool[3] = 29'h40;
    do_reset();
    for (int i = 0; i < MN; i++) begin st[i] = 0; ad[i] = '0; end
    rr = 0; cur = -1;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      missReq = RN'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) missReq = '0;
      for (int l = 0; l < RN; l++) missAddr[l] = pool[$urandom_range(0, 3)];
      memReqReady = 1'($urandom_range(0, 1));
      wq.delete(); fq.delete();
      for (int i = 0; i < MN; i++) begin
        if (st[i] == 2) wq.push_back(i);
        if (st[i] == 3) fq.push_back(i);
      end
      memRespValid = 1'b0; memRespId = '0; fillDone = 1'b0; fillDoneId = '0;
      if (wq.size() > 0 && $urandom_range(0, 1) == 1) begin
        memRespValid = 1'b1; memRespId = IW'(wq[$urandom_range(0, wq.size() - 1)]);
      end
      if (fq.size() > 0 && $urandom_range(0, 1) == 1) begin
        fillDone = 1'b1; fillDoneId = IW'(fq[$urandom_range(0, fq.size() - 1)]);
      end
      e_req = 1'b0; e_rid = 0;
      if (cur >= 0) begin e_req = 1'b1; e_rid = cur; end
      else for (int i = MN - 1; i >= 0; i--) if (st[i] == 1) begin e_req = 1'b1; e_rid = i; end
      free_idx = -1;
      for (int i = MN - 1; i >= 0; i--) if (st[i] == 0) free_idx = i;
      for (int l = 0; l < RN; l++) begin
        mrg[l] = 1'b0; blk[l] = 1'b0; mid[l] = 0;
`ifdef RSD_MARCH_DCACHE_MSHR_MERGE_EN
        for (int i = MN - 1; i >= 0; i--) begin
          if (ad[i] == missAddr[l] && (st[i] == 1 || st[i] == 2)) begin mrg[l] = missReq[l]; mid[l] = i; end
          if (ad[i] == missAddr[l] && st[i] == 3) blk[l] = 1'b1;
        end
`endif
      end
      win = -1;
      if (free_idx >= 0)
        for (int k = 0; k < RN; k++) begin
          int l;
          l = (rr + k) % RN;
          if (win < 0 && missReq[l] && !mrg[l] && !blk[l]) win = l;
        end
      for (int i = 0; i < MN; i++) e_busy[i] = (st[i] != 0);
      #1;
      for (int l = 0; l < RN; l++) begin
        e_g = mrg[l] || (win == l);
        tests++; if (missGrant[l] !== e_g) begin fails++; $display("FAIL rnd_grant cyc=%0d lane=%0d got=%b exp=%b", cyc, l, missGrant[l], e_g); end
        tests++; if (missMerged[l] !== mrg[l]) begin fails++; $display("FAIL rnd_merged cyc=%0d lane=%0d got=%b exp=%b", cyc, l, missMerged[l], mrg[l]); end
        if (e_g) begin
          tests++; if (missGrantId[l] !== IW'(mrg[l] ? mid[l] : free_idx)) begin fails++; $display("FAIL rnd_gid cyc=%0d lane=%0d got=%0d exp=%0d", cyc, l, missGrantId[l], mrg[l] ? mid[l] : free_idx); end
        end
      end
      tests++; if (memReq !== e_req) begin fails++; $display("FAIL rnd_memreq cyc=%0d got=%b exp=%b", cyc, memReq, e_req); end
      if (e_req) begin
        tests++; if (memReqId !== IW'(e_rid) || memReqAddr !== ad[e_rid]) begin fails++; $display("FAIL rnd_memreq_tag cyc=%0d got=%0d/%h exp=%0d/%h", cyc, memReqId, memReqAddr, e_rid, ad[e_rid]); end
      end
      tests++; if (mshrBusy !== e_busy || mshrFull !== (free_idx < 0)) begin fails++; $display("FAIL rnd_busy cyc=%0d got=%b/%b exp=%b/%b", cyc, mshrBusy, mshrFull, e_busy, free_idx < 0); end
      @(posedge clk);
      for (int i = 0; i < MN; i++) old[i] = st[i];
      if (e_req && memReqReady) st[e_rid] = 2;
      if (memRespValid && old[memRespId] == 2) st[memRespId] = 3;
      if (fillDone && old[fillDoneId] == 3) st[fillDoneId] = 0;
      if (win >= 0) begin
        st[free_idx] = 1; ad[free_idx] = missAddr[win]; rr = (win + 1) % RN;
      end
      cur = (e_req && !memReqReady) ? e_rid : -1;
      @(negedge clk);
    end
    idle();
  endtask

  initial begin
    rstN = 1'b0;
    idle();
    @(negedge clk);
    test_reset();
    test_basic_alloc();
    test_round_robin();
    test_full_and_free();
    test_resp_fill_same_cycle();
    test_merge();
    test_reset_midop();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
